instr_feeder: RTL and testbench

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder_pkg.sv | 26 ++
 rtl/instr_feeder_prog_mem.sv | 35 +++
 rtl/instr_feeder.sv | 148 ++++++++++++++
 tb/tb_instr_feeder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: word width, opcode
// constants, FSM state encodings and a small opcode helper.
package instr_feeder_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    FETCH_IMM = 3'd3,
    IMM       = 3'd4,
    WAIT_DONE = 3'd5
  } feederState_t;

  // An MVI is followed by an immediate word that must also be fed.
  function automatic logic isMvi(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3] == OP_MVI;
  endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program memory for the feeder: one synchronous write port and one
// synchronous read port with a single cycle of read latency. Contents are
// deliberately not reset so a loaded program survives a Reset.
module prog_mem
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              Clock,
  input  logic              writeEn,
  input  logic [AW-1:0]     writeAddr,
  input  logic [WORD_W-1:0] writeData,
  input  logic              readEn,
  input  logic [AW-1:0]     readAddr,
  output logic [WORD_W-1:0] readData
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store a word whenever the feeder grants the write strobe.
  always_ff @(posedge Clock) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  // Registered read; the word appears the cycle after readEn.
  always_ff @(posedge Clock) begin
    if (readEn) begin
      readData <= mem[readAddr];
    end
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through a loaded program, presenting each word
// on DIN with a one-cycle Run strobe, feeding MVI immediates without Run,
// and waiting for the processor's Done before moving on.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [AW-1:0]     LoadAddr,
  input  logic [WORD_W-1:0] LoadData,
  input  logic [AW:0]       ProgLen,
  input  logic              Loop,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic              Error
);

  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] PC_ONE    = (AW+1)'(1);

  feederState_t      state, nextState;
  logic [AW:0]       pc, pcNext;
  logic [AW:0]       progLenEff;
  logic              waitArmed;
  logic              memWe, memRe;
  logic [WORD_W-1:0] memRdata;
  logic [WORD_W-1:0] dinNext;
  logic              runNext, finishedNext, errorNext;

  assign progLenEff = (ProgLen > DEPTH_LEN) ? DEPTH_LEN : ProgLen;
  assign memWe      = LoadEn && (state == IDLE);
  assign Busy       = (state != IDLE);

  prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) uProgMem (
    .Clock    (Clock),
    .writeEn  (memWe),
    .writeAddr(LoadAddr),
    .writeData(LoadData),
    .readEn   (memRe),
    .readAddr (pc[AW-1:0]),
    .readData (memRdata)
  );

  // Next-state, PC and output decisions; Abort overrides everything last.
  always_comb begin
    nextState    = state;
    pcNext       = pc;
    dinNext      = DIN;
    runNext      = 1'b0;
    finishedNext = 1'b0;
    errorNext    = Error;
    memRe        = 1'b0;

    case (state)
      IDLE: begin
        if (Start && !LoadEn && (ProgLen != '0)) begin
          nextState = FETCH;
          pcNext    = '0;
          errorNext = 1'b0;
        end
      end
      FETCH: begin
        memRe     = 1'b1;
        nextState = ISSUE;
      end
      ISSUE: begin
        dinNext   = memRdata;
        runNext   = 1'b1;
        pcNext    = pc + PC_ONE;
        nextState = isMvi(memRdata) ? FETCH_IMM : WAIT_DONE;
      end
      FETCH_IMM: begin
        if (pc >= progLenEff) begin
          errorNext = 1'b1;
          nextState = IDLE;
        end else begin
          memRe     = 1'b1;
          nextState = IMM;
        end
      end
      IMM: begin
        dinNext   = memRdata;
        pcNext    = pc + PC_ONE;
        nextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (waitArmed && Done) begin
          if (pc < progLenEff) begin
            nextState = FETCH;
          end else if (Loop) begin
            pcNext    = '0;
            nextState = FETCH;
          end else begin
            finishedNext = 1'b1;
            nextState    = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    if (Abort && (state != IDLE)) begin
      nextState    = IDLE;
      pcNext       = pc;
      dinNext      = DIN;
      runNext      = 1'b0;
      finishedNext = 1'b0;
      errorNext    = Error;
      memRe        = 1'b0;
    end
  end

  // State, PC and registered outputs; waitArmed marks WAIT_DONE cycles after the first.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      pc        <= '0;
      DIN       <= '0;
      Run       <= 1'b0;
      Finished  <= 1'b0;
      Error     <= 1'b0;
      waitArmed <= 1'b0;
    end else begin
      state     <= nextState;
      pc        <= pcNext;
      DIN       <= dinNext;
      Run       <= runNext;
      Finished  <= finishedNext;
      Error     <= errorNext;
      waitArmed <= (state == WAIT_DONE);
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Testbench for instr_feeder: a cycle-by-cycle vector table followed by
// hand-written sequences for looping, abort, async reset and busy writes.
module tb_instr_feeder;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [8:0]    LoadData;
  logic [AW:0]   ProgLen;
  logic          Loop;
  logic          Start;
  logic          Abort;
  logic          Done;
  logic [8:0]    DIN;
  logic          Run;
  logic          Busy;
  logic          Finished;
  logic          Error;

  int checks = 0;
  int errors = 0;

  instr_feeder #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .LoadEn  (LoadEn),
    .LoadAddr(LoadAddr),
    .LoadData(LoadData),
    .ProgLen (ProgLen),
    .Loop    (Loop),
    .Start   (Start),
    .Abort   (Abort),
    .Done    (Done),
    .DIN     (DIN),
    .Run     (Run),
    .Busy    (Busy),
    .Finished(Finished),
    .Error   (Error)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clock = ~Clock;

  typedef struct {
    logic          le;
    logic [AW-1:0] la;
    logic [8:0]    ld;
    logic [AW:0]   pl;
    logic          lp;
    logic          st;
    logic          ab;
    logic          dn;
    logic [8:0]    eDin;
    logic          eRun;
    logic          eBusy;
    logic          eFin;
    logic          eErr;
  } vec_t;

  vec_t vecs[$];

  logic [8:0] runLog[$];
  int         finCount;
  bit         backToBack;
  bit         timedOut;

  function automatic vec_t mkVec(input logic le, input logic [AW-1:0] la, input logic [8:0] ld,
                                 input logic [AW:0] pl, input logic lp, input logic st,
                                 input logic ab, input logic dn, input logic [8:0] eDin,
                                 input logic eRun, input logic eBusy, input logic eFin,
                                 input logic eErr);
    vec_t v;
    v.le = le; v.la = la; v.ld = ld; v.pl = pl; v.lp = lp; v.st = st; v.ab = ab; v.dn = dn;
    v.eDin = eDin; v.eRun = eRun; v.eBusy = eBusy; v.eFin = eFin; v.eErr = eErr;
    return v;
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0o expected=%0o", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    LoadEn   = v.le;
    LoadAddr = v.la;
    LoadData = v.ld;
    ProgLen  = v.pl;
    Loop     = v.lp;
    Start    = v.st;
    Abort    = v.ab;
    Done     = v.dn;
    tick();
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d.DIN", idx), DIN, v.eDin);
    checkOutput($sformatf("vec%0d.Run", idx), {8'b0, Run}, {8'b0, v.eRun});
    checkOutput($sformatf("vec%0d.Busy", idx), {8'b0, Busy}, {8'b0, v.eBusy});
    checkOutput($sformatf("vec%0d.Finished", idx), {8'b0, Finished}, {8'b0, v.eFin});
    checkOutput($sformatf("vec%0d.Error", idx), {8'b0, Error}, {8'b0, v.eErr});
  endtask

  task automatic loadWord(input logic [AW-1:0] addr, input logic [8:0] data);
    LoadEn   = 1'b1;
    LoadAddr = addr;
    LoadData = data;
    tick();
    LoadEn   = 1'b0;
  endtask

  // Start a program with Done tied high and log every Run-pulse word until IDLE.
  task automatic runProgram(input logic [AW:0] len, input bit pokeBusy);
    logic prevRun;
    int   cyc;
    runLog.delete();
    finCount   = 0;
    backToBack = 0;
    timedOut   = 0;
    prevRun    = 1'b0;
    ProgLen    = len;
    Loop       = 1'b0;
    Done       = 1'b1;
    Start      = 1'b1;
    tick();
    Start = 1'b0;
    if (pokeBusy) begin
      LoadEn   = 1'b1;
      LoadAddr = 5'd3;
      LoadData = 9'o777;
    end
    cyc = 0;
    while (Busy && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 3) LoadEn = 1'b0;
      if (Run) runLog.push_back(DIN);
      if (Run && prevRun) backToBack = 1;
      prevRun = Run;
      if (Finished) finCount++;
    end
    LoadEn = 1'b0;
    Done   = 1'b0;
    if (cyc >= 200) timedOut = 1;
  endtask

  task automatic checkProgramRun(input string tag);
    checkOutput({tag, ".timeout"}, {8'b0, timedOut}, 9'd0);
    checkOutput({tag, ".runCount"}, 9'(runLog.size()), 9'd3);
    if (runLog.size() == 3) begin
      checkOutput({tag, ".run0"}, runLog[0], 9'o250);
      checkOutput({tag, ".run1"}, runLog[1], 9'o100);
      checkOutput({tag, ".run2"}, runLog[2], 9'o361);
    end
    checkOutput({tag, ".finished"}, 9'(finCount), 9'd1);
    checkOutput({tag, ".backToBack"}, {8'b0, backToBack}, 9'd0);
    checkOutput({tag, ".Error"}, {8'b0, Error}, 9'd0);
    checkOutput({tag, ".lastDin"}, DIN, 9'o361);
  endtask

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nRun;
    int nFin;
    bit b2b;
    logic prevRun;

    Reset = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0; ProgLen = '0;
    Loop = 1'b0; Start = 1'b0; Abort = 1'b0; Done = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checkOutput("reset.DIN", DIN, 9'd0);
    checkOutput("reset.Run", {8'b0, Run}, 9'd0);
    checkOutput("reset.Busy", {8'b0, Busy}, 9'd0);
    checkOutput("reset.Finished", {8'b0, Finished}, 9'd0);
    checkOutput("reset.Error", {8'b0, Error}, 9'd0);

    //                  le la    ld      pl    lp st ab dn   eDin    eRun eBusy eFin eErr
    // Single non-MVI word, Done raised three cycles after Run.
    vecs.push_back(mkVec(1, 5'd0, 9'o050, 6'd0, 0, 0, 0, 0, 9'o000, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 1, 0, 0, 9'o000, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o000, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o050, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o050, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o050, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o050, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 1, 9'o050, 0, 0, 1, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o050, 0, 0, 0, 0));
    // MVI plus immediate; Done in the first wait cycle must be ignored.
    vecs.push_back(mkVec(1, 5'd0, 9'o100, 6'd0, 0, 0, 0, 0, 9'o050, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 5'd1, 9'd5,   6'd0, 0, 0, 0, 0, 9'o050, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 1, 0, 0, 9'o050, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'o050, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'o100, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'o100, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'd5,   0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 1, 9'd5,   0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 1, 9'd5,   0, 0, 1, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'd5,   0, 0, 0, 0));
    // Start with ProgLen=0, and Start together with LoadEn, are both ignored.
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd0, 0, 1, 0, 0, 9'd5,   0, 0, 0, 0));
    vecs.push_back(mkVec(1, 5'd2, 9'o123, 6'd2, 0, 1, 0, 0, 9'd5,   0, 0, 0, 0));
    // Truncated MVI: Error set, no Finished, back to IDLE.
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 1, 0, 0, 9'd5,   0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'd5,   0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o100, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o100, 0, 0, 0, 1));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd1, 0, 0, 0, 0, 9'o100, 0, 0, 0, 1));
    // New Start clears Error; Abort in FETCH and in ISSUE suppresses Run.
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 1, 0, 0, 9'o100, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 1, 0, 9'o100, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'o100, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 1, 0, 0, 9'o100, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 0, 0, 9'o100, 0, 1, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd2, 0, 0, 1, 0, 9'o100, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 5'd0, 9'o000, 6'd0, 0, 0, 0, 0, 9'o100, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Looping two-word program with Done tied high, then Abort.
    loadWord(5'd0, 9'o250);
    loadWord(5'd1, 9'o361);
    ProgLen = 6'd2; Loop = 1'b1; Done = 1'b1; Start = 1'b1;
    tick();
    Start   = 1'b0;
    nRun    = 0;
    nFin    = 0;
    b2b     = 0;
    prevRun = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (Run) begin
        checkOutput($sformatf("loop.run%0d", nRun), DIN, (nRun % 2 == 0) ? 9'o250 : 9'o361);
        nRun++;
      end
      if (Run && prevRun) b2b = 1;
      prevRun = Run;
      if (Finished) nFin++;
    end
    checkOutput("loop.enoughRuns", {8'b0, nRun >= 8}, 9'd1);
    checkOutput("loop.finished", 9'(nFin), 9'd0);
    checkOutput("loop.backToBack", {8'b0, b2b}, 9'd0);
    checkOutput("loop.busyBeforeAbort", {8'b0, Busy}, 9'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checkOutput("loop.abortBusy", {8'b0, Busy}, 9'd0);
    checkOutput("loop.abortRun", {8'b0, Run}, 9'd0);
    checkOutput("loop.abortFinished", {8'b0, Finished}, 9'd0);
    Loop = 1'b0;
    Done = 1'b0;
    tick();

    // Async reset in the first WAIT_DONE cycle, while Run is high.
    loadWord(5'd0, 9'o250);
    loadWord(5'd1, 9'o100);
    loadWord(5'd2, 9'd7);
    loadWord(5'd3, 9'o361);
    ProgLen = 6'd4; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    checkOutput("rst.preRun", {8'b0, Run}, 9'd1);
    checkOutput("rst.preDin", DIN, 9'o250);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("rst.Run", {8'b0, Run}, 9'd0);
    checkOutput("rst.DIN", DIN, 9'd0);
    checkOutput("rst.Busy", {8'b0, Busy}, 9'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    checkOutput("rst.noResumeBusy", {8'b0, Busy}, 9'd0);
    checkOutput("rst.noResumeRun", {8'b0, Run}, 9'd0);

    // Re-run after reset, with a write to address 3 attempted while busy.
    runProgram(6'd4, 1'b1);
    checkProgramRun("rerun");
    // A later run must still see the original word at address 3.
    runProgram(6'd4, 1'b0);
    checkProgramRun("later");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
